// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_e : fetch FSM states
//   if_err_e    : error code carried with each payload to decode
//   INST_NOP    : addi x0,x0,0, substituted for the instruction on any error
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request issuing
        S_WAIT = 2'd1,  // awaiting response
        S_DROP = 2'd2,  // awaiting a stale response to discard
        S_OUT  = 2'd3   // payload held for decode
    } ifu_state_e;

    typedef enum logic [1:0] {
        IF_ERR_NONE     = 2'd0,
        IF_ERR_MISALIGN = 2'd1,
        IF_ERR_ACCESS   = 2'd2
    } if_err_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: program counter register for the fetch stage.
//   clk, rst_n      : clock, synchronous active-low reset (pc <= RESET_PC)
//   redirect_valid  : load redirect_pc (wins over advance)
//   redirect_pc     : redirect target
//   advance         : step pc by 4, wrapping at 2^XLEN
//   pc              : current pc
//   misalign        : pc is not 4-byte aligned
module ifu_pc_gen #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic            misalign
);

    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else if (advance) begin
            pc_q <= pc_q + {{(XLEN-3){1'b0}}, 3'd4};
        end
    end

    assign pc       = pc_q;
    assign misalign = |pc_q[1:0];

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage. Owns the PC, issues one aligned
// 32-bit fetch at a time and hands {pc, inst, err} to decode.
//   i_clk, i_rst_n                     : clock, synchronous active-low reset
//   o_req_valid/i_req_ready/o_req_addr : fetch request channel
//   i_rsp_valid/i_rsp_data/i_rsp_err   : fetch response (always accepted)
//   i_redirect_valid/i_redirect_pc     : flush and restart fetch
//   o_if_valid/i_id_ready              : payload handshake to decode
//   o_if_pc/o_if_inst/o_if_err         : payload (inst is NOP when err != 0)
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_req_valid,
    input  logic            i_req_ready,
    output logic [XLEN-1:0] o_req_addr,
    input  logic            i_rsp_valid,
    input  logic [31:0]     i_rsp_data,
    input  logic            i_rsp_err,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_if_valid,
    input  logic            i_id_ready,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_if_inst,
    output logic [1:0]      o_if_err
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc;
    logic            misalign;
    logic            req_fire;
    logic            advance;

    logic [XLEN-1:0] if_pc_q;
    logic [31:0]     if_inst_q;
    logic [1:0]      if_err_q;

    logic            load;
    logic [31:0]     load_inst;
    if_err_e         load_err;

    // The pc stays on the instruction being fetched until decode takes it,
    // so it doubles as the payload pc when the response is captured.
    assign advance = (state_q == S_OUT) && i_id_ready && !i_redirect_valid;

    ifu_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk            (i_clk),
        .rst_n          (i_rst_n),
        .redirect_valid (i_redirect_valid),
        .redirect_pc    (i_redirect_pc),
        .advance        (advance),
        .pc             (pc),
        .misalign       (misalign)
    );

    // Reset gates the request so nothing is issued while the state is forced.
    assign o_req_valid = i_rst_n && (state_q == S_REQ) && !misalign;
    assign o_req_addr  = pc;
    assign req_fire    = o_req_valid && i_req_ready;

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_inst = INST_NOP;
        load_err  = IF_ERR_NONE;
        case (state_q)
            S_REQ: begin
                if (i_redirect_valid) begin
                    // An accepted request is in flight; its response is stale.
                    state_d = req_fire ? S_DROP : S_REQ;
                end else if (misalign) begin
                    state_d  = S_OUT;
                    load     = 1'b1;
                    load_err = IF_ERR_MISALIGN;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect_valid) begin
                    state_d = i_rsp_valid ? S_REQ : S_DROP;
                end else if (i_rsp_valid) begin
                    state_d   = S_OUT;
                    load      = 1'b1;
                    load_inst = i_rsp_err ? INST_NOP : i_rsp_data;
                    load_err  = i_rsp_err ? IF_ERR_ACCESS : IF_ERR_NONE;
                end
            end
            S_DROP: begin
                // A redirect here only moves the pc; leave once the stale
                // response has been consumed, even if it coincides with one.
                if (i_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_OUT: begin
                if (i_redirect_valid || i_id_ready) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_REQ;
            if_pc_q   <= '0;
            if_inst_q <= '0;
            if_err_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                if_pc_q   <= pc;
                if_inst_q <= load_inst;
                if_err_q  <= load_err;
            end
        end
    end

    assign o_if_valid = (state_q == S_OUT);
    assign o_if_pc    = if_pc_q;
    assign o_if_inst  = if_inst_q;
    assign o_if_err   = if_err_q;

endmodule
